// File: rtl/booth_mul_arbiter_if.sv
// Request/response bus between the DSP requesters and the shared Booth multiplier.
//   req_valid/req_ready : per-requester handshake, one bit per port
//   req_a/req_b         : signed operands, port i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : product handshake
//   rsp_id              : index of the requester that owns rsp_prod
//   rsp_prod            : signed 2*WIDTH-bit product
// Modports: master = requester/consumer side, slave = multiplier side.
interface booth_mul_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned PW   = 2 * WIDTH;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [PW-1:0]            rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Shared iterative radix-4 Booth multiplier with NUM_REQ-way request arbitration.
// One Booth digit is accumulated per cycle; the signed product is returned
// tagged with the requester index.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : booth_mul_arbiter_if.slave (request ports in, product response out)
// Configuration macro:
//   BOOTH_ARB_FIXED_PRIO_EN : fixed priority (lowest index wins) instead of
//                             round-robin; the round-robin pointer is removed.
module booth_mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_mul_arbiter_if.slave    bus
);
    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] req_ready_c;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

    // Arbitration result and the winner's operands
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;

    // Booth datapath
    logic [WIDTH:0]     b_ext;
    logic [2:0]         trip;
    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      mag;
    logic               neg;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      acc_sum;
    logic               last_digit;

    // Winner selection; the lowest search offset wins because it is visited last
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
`ifdef BOOTH_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(i);
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int unsigned idx;
            idx = 32'(rr_ptr_q) + 32'(k);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req_valid[ID_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
`endif
    end

    // Operand mux for the granted port
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                a_sel = bus.req_a[i*WIDTH +: WIDTH];
                b_sel = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Radix-4 digit for the current count; b_ext carries the implicit b[-1]=0
    always_comb begin
        b_ext = {b_q, 1'b0};
        trip  = 3'(b_ext >> {cnt_q, 1'b0});
        a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        mag   = '0;
        neg   = 1'b0;
        case (trip)
            3'b001, 3'b010: begin mag = a_ext;      neg = 1'b0; end
            3'b011:         begin mag = a_ext << 1; neg = 1'b0; end
            3'b100:         begin mag = a_ext << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_ext;      neg = 1'b1; end
            default:        begin mag = '0;         neg = 1'b0; end
        endcase
        pp         = neg ? (PW'(0) - mag) : mag;
        acc_sum    = acc_q + (pp << {cnt_q, 1'b0});
        last_digit = (cnt_q == CNT_W'(DIGITS - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and the combinational grant
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_c = '0;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Grant is suppressed while reset is held so no handshake is lost
                if (gnt_any && !rst) begin
                    req_ready_c = NUM_REQ'(1) << gnt_id;
                    a_d         = a_sel;
                    b_d         = b_sel;
                    id_d        = gnt_id;
                    acc_d       = '0;
                    cnt_d       = '0;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
                    rr_ptr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
`endif
                    state_d     = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    prod_d      = acc_sum;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = prod_q;

endmodule
